// File: rtl/mod_addsub_pipe_if.sv
// +------------------------------------------------------------------+
// | mod_addsub_pipe_if: valid/ready bus for the modular add/sub pipe |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface mod_addsub_pipe_if #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 4,
  parameter int TAG_WIDTH  = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_op;
  logic [TAG_WIDTH-1:0]         in_tag;
  logic [NUM_CH*DATA_WIDTH-1:0] in_a;
  logic [NUM_CH*DATA_WIDTH-1:0] in_b;
  logic                         out_valid;
  logic                         out_ready;
  logic [TAG_WIDTH-1:0]         out_tag;
  logic [NUM_CH*DATA_WIDTH-1:0] out_res;
  logic [NUM_CH-1:0]            out_err;

  modport master (
    output in_valid, in_op, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_tag, out_res, out_err
  );

  modport slave (
    input  in_valid, in_op, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_tag, out_res, out_err
  );
endinterface

`default_nettype wire

// File: rtl/mod_addsub_pipe.sv
// +------------------------------------------------------------------+
// | mod_addsub_pipe: two-stage multi-lane modular adder/subtractor   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mod_addsub_pipe #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147,
  parameter int NUM_CH     = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  mod_addsub_pipe_if.slave    bus
);

  localparam int               LW      = NUM_CH * DATA_WIDTH;
  localparam logic [DATA_WIDTH:0] MOD_EXT = MODULUS[DATA_WIDTH:0];

  // Handshake state
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s1_load;
  logic s2_load;

  // Stage-1 registers: both candidates (truncated) plus the deciding sign
  logic                 s1_op_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [LW-1:0]        s1_d0_q, s1_d0_d;
  logic [LW-1:0]        s1_d1_q, s1_d1_d;
  logic [NUM_CH-1:0]    s1_sgn_q, s1_sgn_d;
  logic [NUM_CH-1:0]    s1_err_q, s1_err_d;

  // Output registers
  logic [LW-1:0]        out_res_q, out_res_d;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic [NUM_CH-1:0]    out_err_q;

  assign s2_load = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign s1_load = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [DATA_WIDTH:0] a_ext;
      logic [DATA_WIDTH:0] b_ext;
      logic [DATA_WIDTH:0] dif;
      logic [DATA_WIDTH:0] dif_corr;
      logic [DATA_WIDTH:0] sum;
      logic [DATA_WIDTH:0] sum_corr;
      logic [DATA_WIDTH-1:0] d0_q;
      logic [DATA_WIDTH-1:0] d1_q;

      assign a_ext    = {1'b0, bus.in_a[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign b_ext    = {1'b0, bus.in_b[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign dif      = a_ext - b_ext;
      assign dif_corr = dif + MOD_EXT;
      assign sum      = a_ext + b_ext;
      assign sum_corr = sum - MOD_EXT;

      // d0 is the raw result, d1 the modulus-corrected one; the sign bit
      // that decides between them is sign(d0) for sub and sign(d1) for add.
      assign s1_d0_d[gi*DATA_WIDTH +: DATA_WIDTH] =
        bus.in_op ? sum[DATA_WIDTH-1:0] : dif[DATA_WIDTH-1:0];
      assign s1_d1_d[gi*DATA_WIDTH +: DATA_WIDTH] =
        bus.in_op ? sum_corr[DATA_WIDTH-1:0] : dif_corr[DATA_WIDTH-1:0];
      assign s1_sgn_d[gi] = bus.in_op ? sum_corr[DATA_WIDTH] : dif[DATA_WIDTH];
      assign s1_err_d[gi] = (a_ext >= MOD_EXT) || (b_ext >= MOD_EXT);

      assign d0_q = s1_d0_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign d1_q = s1_d1_q[gi*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        out_res_d[gi*DATA_WIDTH +: DATA_WIDTH] = d0_q;
        if (s1_op_q) begin
          out_res_d[gi*DATA_WIDTH +: DATA_WIDTH] = s1_sgn_q[gi] ? d0_q : d1_q;
        end else begin
          out_res_d[gi*DATA_WIDTH +: DATA_WIDTH] = s1_sgn_q[gi] ? d1_q : d0_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_tag_q    <= '0;
      s1_d0_q     <= '0;
      s1_d1_q     <= '0;
      s1_sgn_q    <= '0;
      s1_err_q    <= '0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      out_err_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      // Data registers move only on a load so idle cycles do not toggle them
      if (s1_load) begin
        s1_op_q  <= bus.in_op;
        s1_tag_q <= bus.in_tag;
        s1_d0_q  <= s1_d0_d;
        s1_d1_q  <= s1_d1_d;
        s1_sgn_q <= s1_sgn_d;
        s1_err_q <= s1_err_d;
      end
      if (s2_load) begin
        out_res_q <= out_res_d;
        out_tag_q <= s1_tag_q;
        out_err_q <= s1_err_q;
      end
    end
  end

  assign bus.in_ready  = !s1_valid_q || s2_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule

`default_nettype wire
